// File: rtl/nios_system_debug_sync_ctrl_pkg.sv
// Shared encodings for the multicore debug halt/resume sequencer:
// command opcodes, completion status codes and FSM state values.
package nios_system_debug_ctrl_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_HALT   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STEP   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADMASK = 2'b10;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_HALT_WAIT = 2'd1;
  localparam logic [1:0] S_RES_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  typedef enum logic [1:0] {
    STATE_IDLE      = S_IDLE,
    STATE_HALT_WAIT = S_HALT_WAIT,
    STATE_RES_WAIT  = S_RES_WAIT,
    STATE_DONE      = S_DONE
  } state_e;

endpackage

// File: rtl/nios_system_debug_sync_ctrl_if.sv
// Command/status bundle between the host debug command source, the
// sequencer and the per-core debug modules.
interface nios_system_debug_sync_ctrl_if #(
  parameter int NUM_CPU = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [NUM_CPU-1:0] cmd_mask;
  logic [NUM_CPU-1:0] debugreq;
  logic [NUM_CPU-1:0] resume_pulse;
  logic [NUM_CPU-1:0] debugack;
  logic               done;
  logic [1:0]         done_status;
  logic [NUM_CPU-1:0] halted;
  logic               busy;

  // Host side plus the core models: issues commands, drives acknowledges.
  modport master (
    output cmd_valid, cmd_op, cmd_mask, debugack,
    input  cmd_ready, debugreq, resume_pulse, done, done_status, halted, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, debugack,
    output cmd_ready, debugreq, resume_pulse, done, done_status, halted, busy
  );
endinterface

// File: rtl/nios_system_debug_sync_ctrl_timeout_cnt.sv
// Wait-state timeout counter: cleared on entry to a wait state, counts
// while enabled and saturates at TIMEOUT_CYC, where expired is raised.
module nios_system_debug_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] count;

  // Count wait cycles, holding at the limit so expired stays asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/nios_system_debug_sync_ctrl.sv
// Multicore debug halt/resume sequencer. Accepts one command at a time,
// drives debugreq / resume_pulse to the selected cores, waits for their
// debugack levels and reports completion or timeout with a done strobe.
module nios_system_debug_sync_ctrl
  import nios_system_debug_ctrl_pkg::*;
#(
  parameter int NUM_CPU     = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic clk,
  input logic reset,
  nios_system_debug_sync_ctrl_if.slave bus
);

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [1:0]         op_q;
  logic [1:0]         op_n;
  logic [NUM_CPU-1:0] mask_q;
  logic [NUM_CPU-1:0] mask_n;
  logic [NUM_CPU-1:0] req_q;
  logic [NUM_CPU-1:0] req_n;
  logic [NUM_CPU-1:0] resume_q;
  logic [NUM_CPU-1:0] resume_n;
  logic [NUM_CPU-1:0] halted_q;
  logic [1:0]         status_q;
  logic [1:0]         status_n;
  logic               done_q;
  logic               done_n;
  logic               ready_q;
  logic               busy_q;
  logic               all_acked;
  logic               all_released;
  logic               cnt_clr;
  logic               cnt_en;
  logic               expired;

  // Only cores in the latched mask matter; other acknowledges are ignored.
  assign all_acked    = ((bus.debugack & mask_q) == mask_q);
  assign all_released = ((bus.debugack & mask_q) == '0);

  nios_system_debug_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Sequencer next-state, request and status decisions.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    mask_n   = mask_q;
    req_n    = req_q;
    resume_n = '0;
    status_n = status_q;
    done_n   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_n   = bus.cmd_op;
          mask_n = bus.cmd_mask;
          if (bus.cmd_op == OP_NOP) begin
            state_n  = S_DONE;
            status_n = ST_OK;
            done_n   = 1'b1;
          end else if (bus.cmd_mask == '0) begin
            // Empty target set: report without touching any request line.
            state_n  = S_DONE;
            status_n = ST_BADMASK;
            done_n   = 1'b1;
          end else begin
            case (bus.cmd_op)
              OP_HALT: begin
                state_n = S_HALT_WAIT;
                req_n   = req_q | bus.cmd_mask;
              end
              OP_RESUME, OP_STEP: begin
                state_n  = S_RES_WAIT;
                req_n    = req_q & ~bus.cmd_mask;
                resume_n = bus.cmd_mask;
              end
              default: begin
                state_n  = S_DONE;
                status_n = ST_OK;
                done_n   = 1'b1;
              end
            endcase
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HALT_WAIT: begin
        cnt_clr = 1'b0;
        if (all_acked) begin
          state_n  = S_DONE;
          status_n = ST_OK;
          done_n   = 1'b1;
        end else if (expired) begin
          // Give up on cores that never acked; acked cores stay requested.
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
          done_n   = 1'b1;
          req_n    = req_q & ~(mask_q & ~bus.debugack);
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RES_WAIT: begin
        cnt_clr = 1'b0;
        if (all_released) begin
          if (op_q == OP_STEP) begin
            // Cores have run at least one cycle: re-halt them.
            state_n = S_HALT_WAIT;
            req_n   = req_q | mask_q;
            cnt_clr = 1'b1;
          end else begin
            state_n  = S_DONE;
            status_n = ST_OK;
            done_n   = 1'b1;
          end
        end else if (expired) begin
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
          done_n   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs; reset drops requests at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      mask_q   <= '0;
      req_q    <= '0;
      resume_q <= '0;
      status_q <= ST_OK;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      halted_q <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      mask_q   <= mask_n;
      req_q    <= req_n;
      resume_q <= resume_n;
      status_q <= status_n;
      done_q   <= done_n;
      ready_q  <= (state_n == S_IDLE);
      busy_q   <= (state_n != S_IDLE);
      halted_q <= bus.debugack;
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.debugreq     = req_q;
  assign bus.resume_pulse = resume_q;
  assign bus.done         = done_q;
  assign bus.done_status  = status_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_nios_system_debug_sync_ctrl.sv
// Self-checking bench for the debug halt/resume sequencer. Each command is
// predicted from ack timing tables (done cycle, status, request vector per
// cycle) and compared cycle by cycle against the DUT.
module tb_nios_system_debug_sync_ctrl;
  import nios_system_debug_ctrl_pkg::*;

  localparam int N     = 4;
  localparam int T     = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [N-1:0] exp_req;
  logic [N-1:0] cur_ack;
  logic [N-1:0] base_ack;
  int           rise [N];
  int           fall [N];

  nios_system_debug_sync_ctrl_if #(.NUM_CPU(N)) bus ();

  nios_system_debug_sync_ctrl #(
    .NUM_CPU     (N),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tables;
    for (int i = 0; i < N; i++) begin
      rise[i] = NEVER;
      fall[i] = NEVER;
    end
  endtask

  // Ack level of core i in cycle j relative to acceptance (cycle 0).
  function automatic logic ack_at(int i, int j);
    if (j >= rise[i]) return 1'b1;
    else if (j >= fall[i]) return 1'b0;
    else return base_ack[i];
  endfunction

  function automatic int first_high(int i, int from);
    for (int j = from; j < NEVER; j++) if (ack_at(i, j)) return j;
    return NEVER;
  endfunction

  function automatic int first_low(int i, int from);
    for (int j = from; j < NEVER; j++) if (!ack_at(i, j)) return j;
    return NEVER;
  endfunction

  // Issue one command, predict its outcome and check every cycle until idle.
  task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] m,
                         input bit noise, input string name);
    int exp_done, k, e, k2, lo_until, c;
    logic [1:0]   exp_st;
    logic [N-1:0] lo, hi, fin, em, a, exp_r, exp_rp;
    bit           exp_rdy;
    base_ack = cur_ack;
    em       = (op != OP_NOP && m != '0) ? m : '0;
    lo = exp_req; hi = exp_req; fin = exp_req; lo_until = 0;
    exp_st = ST_OK;
    if (op == OP_NOP) begin
      exp_done = 1;
    end else if (m == '0) begin
      exp_done = 1; exp_st = ST_BADMASK;
    end else if (op == OP_HALT) begin
      hi = exp_req | m;
      k = 1;
      for (int i = 0; i < N; i++) if (m[i]) k = (first_high(i, 1) > k) ? first_high(i, 1) : k;
      if (k <= T + 1) begin
        exp_done = k + 1; fin = hi;
      end else begin
        exp_done = T + 2; exp_st = ST_TIMEOUT; fin = hi;
        for (int i = 0; i < N; i++) if (m[i] && !ack_at(i, T + 1)) fin[i] = 1'b0;
      end
    end else begin
      lo = exp_req & ~m; hi = exp_req | m; lo_until = NEVER; fin = lo;
      k = 1;
      for (int i = 0; i < N; i++) if (m[i]) k = (first_low(i, 1) > k) ? first_low(i, 1) : k;
      if (k > T + 1) begin
        exp_done = T + 2; exp_st = ST_TIMEOUT;
      end else if (op == OP_RESUME) begin
        exp_done = k + 1;
      end else begin
        lo_until = k; e = k + 1; k2 = e;
        for (int i = 0; i < N; i++) if (m[i]) k2 = (first_high(i, e) > k2) ? first_high(i, e) : k2;
        if (k2 <= e + T) begin
          exp_done = k2 + 1; fin = hi;
        end else begin
          exp_done = e + T + 1; exp_st = ST_TIMEOUT; fin = hi;
          for (int i = 0; i < N; i++) if (m[i] && !ack_at(i, e + T)) fin[i] = 1'b0;
        end
      end
    end

    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept_ready: got %b expected 1", name, bus.cmd_ready);
    end
    n_vec++;

    for (int j = 0; j <= exp_done; j++) begin
      bus.cmd_valid = (j == 0);
      if (j == 0) begin
        bus.cmd_op = op; bus.cmd_mask = m;
      end else begin
        bus.cmd_op = 2'($urandom_range(0, 3)); bus.cmd_mask = N'($urandom_range(0, 15));
      end
      for (int i = 0; i < N; i++) begin
        if (em[i]) a[i] = ack_at(i, j);
        else if (noise && j > 0) a[i] = 1'($urandom_range(0, 1));
        else a[i] = cur_ack[i];
      end
      bus.debugack = a;
      cur_ack = a;
      tick;
      c = j + 1;
      exp_rdy = (c > exp_done);
      exp_r   = (c <= lo_until) ? lo : ((c < exp_done) ? hi : fin);
      exp_rp  = (c == 1 && (op == OP_RESUME || op == OP_STEP) && m != '0) ? m : '0;
      n_vec += 6;
      if (bus.cmd_ready !== exp_rdy) begin
        n_bad++; $display("FAIL %s ready c%0d: got %b expected %b", name, c, bus.cmd_ready, exp_rdy);
      end
      if (bus.busy !== !exp_rdy) begin
        n_bad++; $display("FAIL %s busy c%0d: got %b expected %b", name, c, bus.busy, !exp_rdy);
      end
      if (bus.done !== (c == exp_done)) begin
        n_bad++; $display("FAIL %s done c%0d: got %b expected %b", name, c, bus.done, (c == exp_done));
      end
      if (bus.resume_pulse !== exp_rp) begin
        n_bad++; $display("FAIL %s resume_pulse c%0d: got %b expected %b", name, c, bus.resume_pulse, exp_rp);
      end
      if (bus.debugreq !== exp_r) begin
        n_bad++; $display("FAIL %s debugreq c%0d: got %b expected %b", name, c, bus.debugreq, exp_r);
      end
      if (bus.halted !== a) begin
        n_bad++; $display("FAIL %s halted c%0d: got %b expected %b", name, c, bus.halted, a);
      end
      if (c >= exp_done) begin
        n_vec++;
        if (bus.done_status !== exp_st) begin
          n_bad++; $display("FAIL %s status c%0d: got %b expected %b", name, c, bus.done_status, exp_st);
        end
      end
    end
    bus.cmd_valid = 1'b0;
    exp_req = fin;
  endtask

  task automatic check_idle_reset_values(input string name);
    n_vec += 7;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL %s cmd_ready: got %b expected 1", name, bus.cmd_ready); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b expected 0", name, bus.busy); end
    if (bus.debugreq !== 4'b0000) begin n_bad++; $display("FAIL %s debugreq: got %b expected 0000", name, bus.debugreq); end
    if (bus.resume_pulse !== 4'b0000) begin n_bad++; $display("FAIL %s resume_pulse: got %b expected 0000", name, bus.resume_pulse); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL %s done: got %b expected 0", name, bus.done); end
    if (bus.done_status !== 2'b00) begin n_bad++; $display("FAIL %s done_status: got %b expected 00", name, bus.done_status); end
    if (bus.halted !== 4'b0000) begin n_bad++; $display("FAIL %s halted: got %b expected 0000", name, bus.halted); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_mask = '0; bus.debugack = '0;
    repeat (3) tick;
    check_idle_reset_values("reset_held");
    reset = 1'b0;
    tick;
    check_idle_reset_values("reset_released");
    exp_req = '0; cur_ack = '0;
  endtask

  task automatic test_halt_timeout;
    clear_tables();
    rise[0] = 2;
    run_cmd(OP_HALT, 4'b0011, 1'b0, "halt_timeout");
    n_vec++;
    if (bus.debugreq !== 4'b0001) begin
      n_bad++; $display("FAIL halt_timeout final_req: got %b expected 0001", bus.debugreq);
    end
  endtask

  task automatic test_resume_core0;
    clear_tables();
    fall[0] = 2;
    run_cmd(OP_RESUME, 4'b0001, 1'b0, "resume_core0");
  endtask

  task automatic test_halt_two;
    clear_tables();
    rise[0] = 3; rise[2] = 5;
    run_cmd(OP_HALT, 4'b0101, 1'b0, "halt_two");
    n_vec++;
    if (bus.debugreq !== 4'b0101) begin
      n_bad++; $display("FAIL halt_two final_req: got %b expected 0101", bus.debugreq);
    end
    clear_tables();
    rise[1] = 2; rise[3] = 4;
    run_cmd(OP_HALT, 4'b1010, 1'b0, "halt_rest");
  endtask

  task automatic test_step;
    clear_tables();
    fall[3] = 3; rise[3] = 6;
    run_cmd(OP_STEP, 4'b1000, 1'b0, "step");
    n_vec++;
    if (bus.debugreq !== 4'b1111) begin
      n_bad++; $display("FAIL step final_req: got %b expected 1111", bus.debugreq);
    end
  endtask

  task automatic test_badmask_nop;
    clear_tables();
    run_cmd(OP_HALT, 4'b0000, 1'b0, "badmask_halt");
    run_cmd(OP_STEP, 4'b0000, 1'b0, "badmask_step");
    run_cmd(OP_NOP, N'($urandom_range(0, 15)), 1'b0, "nop");
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] m;
    m = N'($urandom_range(1, 15));
    exp_req = exp_req | m;
    for (int j = 0; j < 12; j++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT; bus.cmd_mask = m; bus.debugack = 4'b1111;
      n_vec += 3;
      if (bus.cmd_ready !== (j % 3 == 0)) begin
        n_bad++; $display("FAIL b2b ready c%0d: got %b expected %b", j, bus.cmd_ready, (j % 3 == 0));
      end
      if (bus.busy !== (j % 3 != 0)) begin
        n_bad++; $display("FAIL b2b busy c%0d: got %b expected %b", j, bus.busy, (j % 3 != 0));
      end
      if (bus.done !== (j % 3 == 2)) begin
        n_bad++; $display("FAIL b2b done c%0d: got %b expected %b", j, bus.done, (j % 3 == 2));
      end
      tick;
    end
    bus.cmd_valid = 1'b0;
    cur_ack = 4'b1111;
    n_vec += 2;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b final_ready: got %b expected 1", bus.cmd_ready); end
    if (bus.debugreq !== exp_req) begin n_bad++; $display("FAIL b2b final_req: got %b expected %b", bus.debugreq, exp_req); end
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic [N-1:0] m;
    int k;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      m  = N'($urandom_range(0, 15));
      clear_tables();
      base_ack = cur_ack;
      for (int i = 0; i < N; i++) begin
        if (op == OP_HALT && !cur_ack[i])
          rise[i] = ($urandom_range(0, 5) == 0) ? NEVER : 1 + $urandom_range(0, 9);
        if ((op == OP_RESUME || op == OP_STEP) && cur_ack[i])
          fall[i] = ($urandom_range(0, 7) == 0) ? NEVER : 1 + $urandom_range(0, 9);
      end
      if (op == OP_STEP) begin
        k = 1;
        for (int i = 0; i < N; i++) if (m[i]) k = (first_low(i, 1) > k) ? first_low(i, 1) : k;
        if (k <= T + 1)
          for (int i = 0; i < N; i++)
            rise[i] = ($urandom_range(0, 5) == 0) ? NEVER : k + 1 + $urandom_range(0, 9);
      end
      run_cmd(op, m, 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid;
    bus.debugack = 4'b0000;
    tick;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT; bus.cmd_mask = 4'b1111;
    tick;
    bus.cmd_valid = 1'b0; bus.debugack = 4'b0101;
    repeat (3) tick;
    #3;
    reset = 1'b1;
    #1;
    check_idle_reset_values("reset_mid");
    tick;
    tick;
    reset = 1'b0;
    bus.debugack = '0; cur_ack = '0; exp_req = '0;
    for (int j = 0; j < 3; j++) begin
      tick;
      n_vec += 2;
      if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_mid no_done c%0d: got %b expected 0", j, bus.done); end
      if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid ready c%0d: got %b expected 1", j, bus.cmd_ready); end
    end
    clear_tables();
    rise[1] = 2; rise[2] = 4;
    run_cmd(OP_HALT, 4'b0110, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_halt_timeout();
    test_resume_core0();
    test_halt_two();
    test_step();
    test_badmask_nop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_system_debug_sync_ctrl.md
# nios_system_debug_sync_ctrl

Multicore debug halt/resume sequencer for the multi-CPU Nios II system. It accepts one host-level debug command at a time and applies it to a selected subset of NUM_CPU cores. It drives each core's debug break request, waits for that core's debug acknowledge, and reports completion or timeout. It sits between the host-side debug command source and the per-CPU debug module inputs (debugreq in, debugack out), so that a set of cores is halted, resumed or single-stepped as one coordinated operation.

## Interface
Parameters:
- NUM_CPU, 4, number of cores under control (1..8)
- TIMEOUT_CYC, 1023, wait-state cycles before a command aborts (≥2); counter width is clog2(TIMEOUT_CYC+1)

Ports:
- clk  in  1  system clock; the block has a single clock domain
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle; a command is accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 NOP, 01 HALT, 10 RESUME, 11 STEP
- cmd_mask  in  NUM_CPU  target cores, sampled at acceptance
- debugreq  out  NUM_CPU  per-core break request, level, registered
- resume_pulse  out  NUM_CPU  per-core one-cycle resume strobe, registered
- debugack  in  NUM_CPU  per-core "in debug mode" level, same clock
- done  out  1  one-cycle completion strobe
- done_status  out  2  00 OK, 01 TIMEOUT, 10 BADMASK; valid while done=1, holds its value until the next done
- halted  out  NUM_CPU  registered copy of debugack
- busy  out  1  equals !cmd_ready

## Operation
- States: IDLE, HALT_WAIT, RES_WAIT, DONE.
- IDLE: cmd_ready=1. On acceptance, latch mask_q=cmd_mask and op_q=cmd_op, then:
  - NOP → DONE, status OK.
  - mask==0 with op≠NOP → DONE, status BADMASK; debugreq and resume_pulse are untouched.
  - HALT → HALT_WAIT; debugreq |= mask_q.
  - RESUME or STEP → RES_WAIT; debugreq &= ~mask_q; resume_pulse = mask_q for exactly one cycle.
- HALT_WAIT:
  - When (debugack & mask_q) == mask_q → DONE, status OK.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC → DONE, status TIMEOUT, and debugreq bits of unacked masked cores are cleared. Acked cores stay requested.
- RES_WAIT:
  - When (debugack & mask_q) == 0:
    - RESUME → DONE, status OK.
    - STEP → HALT_WAIT with debugreq |= mask_q and the counter cleared. This re-halts after at least one free-running cycle.
  - Timeout → DONE, status TIMEOUT. debugreq stays cleared.
- DONE: done=1 for one cycle, then → IDLE.
- The timeout counter clears on every entry into HALT_WAIT or RES_WAIT.
- debugreq bits outside mask_q never change during a command.
- debugack changes on unmasked cores are ignored.

## Timing
- Reset values: cmd_ready=1, busy=0, debugreq=0, resume_pulse=0, done=0, done_status=00, halted=0. The state register goes to IDLE.
- Reset mid-command drops all requests immediately (asynchronously) and does not produce a done strobe.
- HALT with debugack already set on all masked cores:
  - accept at cycle 0
  - debugreq high and state HALT_WAIT at cycle 1
  - DONE at cycle 2
  - cmd_ready=1 at cycle 3
  - Minimum command latency is therefore 3 cycles from acceptance to the next accept.
- Acknowledge arriving at cycle k in HALT_WAIT → done at cycle k+1.
- TIMEOUT: done occurs TIMEOUT_CYC+1 cycles after wait-state entry.
- resume_pulse is high only in the cycle after acceptance (RESUME or STEP) and never in any other cycle.
- cmd_valid while busy is ignored. No queueing is performed; the requester holds cmd_valid until it is accepted.
- halted lags debugack by 1 cycle.

## Structure
- Package nios_system_debug_ctrl_pkg holds:
  - op encoding constants (OP_NOP/HALT/RESUME/STEP)
  - status constants (ST_OK/TIMEOUT/BADMASK)
  - state enum typedef
- Sub-module nios_system_debug_timeout_cnt: parameter TIMEOUT_CYC; inputs clr and en; output expired (count==TIMEOUT_CYC); async active-high reset.
- The FSM, mask register and request registers live in the top module.

## Test plan
- Reset, then HALT with mask=4'b0101; a model raises debugack[0] at +3 cycles and debugack[2] at +5 cycles → debugreq=0101; done with OK one cycle after debugack[2]; halted=0101 one cycle later.
- HALT mask=4'b0011 where core1 never acks, TIMEOUT_CYC=8 → done at entry+9 cycles with TIMEOUT; final debugreq=0001.
- With all cores halted, STEP mask=4'b1000 → resume_pulse=1000 for one cycle; debugreq[3]=0 until the model drops debugack[3]; then debugreq[3]=1; done OK after the re-ack; other bits stay constant throughout.
- HALT with mask=0 → done one cycle after acceptance with BADMASK; debugreq unchanged. NOP → done with OK.
- cmd_valid held high across a HALT → exactly one accept per IDLE cycle; no accept while busy=1.
- Assert reset in the middle of HALT_WAIT → all outputs return to their reset values in the same cycle; no done strobe; the next command is accepted normally.
